// File: rtl/word_extract_buffer.sv
// Single-line read buffer: serves 16-bit word reads from one buffered 128-bit line, fetching on a miss.
// Optional macro WORD_ALIGN_FORCE_EN forces offset bit 0 to zero before word extraction.
module word_extract_buffer (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic [15:0]  mem_address,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    input  logic         invalidate,
    output logic         pmem_read,
    output logic [15:0]  pmem_address,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [127:0]   line_q, line_d;
    logic [11:0]    tag_q, tag_d;
    logic           valid_q, valid_d;
    logic [3:0]     offset_q, offset_d;

    logic           hit;
    logic [3:0]     eff_offset;
    logic [7:0]     bit_idx;
    logic [135:0]   line_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            line_q   <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            offset_q <= offset_d;
        end
    end

    assign hit = valid_q && (mem_address[15:4] == tag_q);

    always_comb begin
        // NOTE: every signal gets a hold/idle default first so no path can infer a latch.
        state_d   = state_q;
        line_d    = line_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        offset_d  = offset_q;
        mem_resp  = 1'b0;
        pmem_read = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read) begin
                    offset_d = mem_address[3:0];
                    if (hit) begin
                        state_d = RESPOND;
                    end else begin
                        tag_d   = mem_address[15:4];
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    line_d  = pmem_rdata;
                    valid_d = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                mem_resp = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Invalidate wins over a fill landing in the same cycle; the fetch itself still completes.
        if (invalidate) begin
            valid_d = 1'b0;
        end
    end

    assign pmem_address = {tag_q, 4'b0000};

`ifdef WORD_ALIGN_FORCE_EN
    assign eff_offset = offset_q & 4'b1110;
`else
    assign eff_offset = offset_q;
`endif

    // Zero byte above the line so offset 15 reads 8'h00 in the high lane.
    assign line_ext  = {8'h00, line_q};
    assign bit_idx   = {1'b0, eff_offset, 3'b000};
    assign mem_rdata = mem_resp ? line_ext[bit_idx +: 16] : 16'h0000;

endmodule

// File: tb/tb_word_extract_buffer.sv
// Self-checking bench for word_extract_buffer: directed scenarios plus randomized reads
// against a byte-array model of the buffered line.
module tb_word_extract_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read;
    logic [15:0]  mem_address;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         invalidate;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the buffer should currently hold.
    logic         m_valid;
    logic [11:0]  m_tag;
    logic [7:0]   m_bytes [16];

    word_extract_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .invalidate   (invalidate),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [3:0] off);
        int         eff;
        logic [7:0] hi;
        eff = int'(off);
`ifdef WORD_ALIGN_FORCE_EN
        eff = eff - (eff % 2);
`endif
        hi = (eff < 15) ? m_bytes[eff + 1] : 8'h00;
        return {hi, m_bytes[eff]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one read at #1 after an edge; mem_read stays high through RESPOND.
    task automatic do_read(input logic [15:0] addr, input int delay, input logic [127:0] line,
                           input bit inv_at_fill, output logic [15:0] got);
        bit exp_hit;
        exp_hit     = m_valid && (m_tag == addr[15:4]);
        mem_read    = 1'b1;
        mem_address = addr;
        got         = 16'hxxxx;
        next_cycle();
        if (exp_hit) begin
            check("hit_pmem_read", pmem_read, 0);
            check("hit_resp", mem_resp, 1);
            check("hit_rdata", mem_rdata, exp_word(addr[3:0]));
            got = mem_rdata;
        end else begin
            check("miss_resp_early", mem_resp, 0);
            check("miss_pmem_read", pmem_read, 1);
            check("miss_pmem_addr", pmem_address, {addr[15:4], 4'h0});
            for (int i = 0; i < delay; i++) begin
                next_cycle();
                check("fetch_hold", {pmem_read, mem_resp, pmem_address}, {2'b10, addr[15:4], 4'h0});
            end
            pmem_resp  = 1'b1;
            pmem_rdata = line;
            invalidate = inv_at_fill;
            next_cycle();
            pmem_resp  = 1'b0;
            pmem_rdata = $urandom;
            invalidate = 1'b0;
            m_tag      = addr[15:4];
            m_valid    = !inv_at_fill;
            for (int b = 0; b < 16; b++) m_bytes[b] = line[8*b +: 8];
            check("fill_pmem_read", pmem_read, 0);
            check("fill_resp", mem_resp, 1);
            check("fill_rdata", mem_rdata, exp_word(addr[3:0]));
            got = mem_rdata;
        end
        next_cycle();
        mem_read = 1'b0;
        check("after_resp", {mem_resp, pmem_read, mem_rdata}, 18'h0);
    endtask

    task automatic pulse_invalidate();
        invalidate = 1'b1;
        next_cycle();
        invalidate = 1'b0;
        m_valid    = 1'b0;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] RAMP = 128'h0F0E0D0C0B0A09080706050403020100;

    initial begin
        logic [15:0] got;
        reset       = 1'b1;
        mem_read    = 1'b0;
        mem_address = '0;
        invalidate  = 1'b0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        m_valid     = 1'b0;
        m_tag       = '0;
        for (int b = 0; b < 16; b++) m_bytes[b] = 8'h00;

        #1;
        check("reset_outputs", {mem_resp, pmem_read, mem_rdata}, 18'h0);
        check("reset_pmem_addr", pmem_address, 16'h0000);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        check("idle_outputs", {mem_resp, pmem_read, mem_rdata}, 18'h0);

        // Cold miss, hit, top-offset read.
        do_read(16'h1234, 3, RAMP, 1'b0, got);
        check("dir_cold_miss", got, 16'h0504);
        do_read(16'h123A, 0, RAMP, 1'b0, got);
        check("dir_hit", got, 16'h0B0A);
        do_read(16'h123F, 0, RAMP, 1'b0, got);
`ifdef WORD_ALIGN_FORCE_EN
        check("dir_off15", got, 16'h0F0E);
`else
        check("dir_off15", got, 16'h000F);
`endif

        // Invalidate then refetch.
        pulse_invalidate();
        do_read(16'h1230, 2, RAMP, 1'b0, got);
        check("dir_refetch", got, 16'h0100);

        // Invalidate coincident with fill: served, but next read misses.
        do_read(16'h4560, 1, RAMP, 1'b1, got);
        check("dir_inv_fill", got, 16'h0100);
        do_read(16'h4562, 0, RAMP, 1'b0, got);
        check("dir_inv_fill_next", got, 16'h0302);

        // Reset in the middle of a fetch.
        mem_read    = 1'b1;
        mem_address = 16'h7777;
        next_cycle();
        check("rst_fetch_started", pmem_read, 1);
        next_cycle();
        #2 reset = 1'b1;
        #1;
        check("rst_mid_fetch", {mem_resp, pmem_read, mem_rdata}, 18'h0);
        mem_read = 1'b0;
        m_valid  = 1'b0;
        next_cycle();
        reset      = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        next_cycle();
        pmem_resp = 1'b0;
        check("late_resp_ignored", {mem_resp, pmem_read}, 2'b00);
        next_cycle();
        check("late_resp_idle", {mem_resp, pmem_read}, 2'b00);
        do_read(16'h7776, 1, RAMP, 1'b0, got);
        check("post_reset_miss", got, 16'h0706);

        // Randomized traffic over a few tags so hits and misses both occur.
        for (int n = 0; n < 200; n++) begin
            logic [15:0] addr;
            addr = {12'h7F0 + 12'($urandom_range(0, 2)), 4'($urandom)};
            if ($urandom_range(0, 9) == 0) pulse_invalidate();
            do_read(addr, $urandom_range(0, 4), rand_line(), ($urandom_range(0, 7) == 0), got);
            for (int g = $urandom_range(0, 2); g > 0; g--) next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
